// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Sole owner of the byte-wide RAM/IO port. Serialises byte transfers for three
// requesters (instruction fetch, load issue, committed store). Priority is
// fixed: store > load > fetch. A transaction, once accepted, is never
// preempted. Read bytes are assembled little-endian and returned with a
// one-cycle done pulse. Every done pulse is followed by one dead IDLE cycle,
// so a request line that is still high is not accepted a second time.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   rdy              global ready; low freezes the engine and blocks writes
//   rb               rollback: aborts fetch/load, blocks fetch/load accept
//   if_ena/if_addr   fetch request (always 4 bytes)
//   if_done/if_data  fetch completion pulse and word
//   ld_ena/ld_addr/ld_len/ld_src   load request (len = bytes-1, ROB tag)
//   ld_done/ld_data/ld_tag         load completion, zero-extended data, tag
//   st_ena/st_addr/st_len/st_data  store request (len = bytes-1)
//   st_done          store completion pulse
//   mem_din          RAM read byte for the address presented this cycle
//   mem_dout/mem_a/mem_wr          RAM write byte, byte address, write strobe
//   io_full          IO buffer full; stalls writes into the IO region
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int         ROB_BIT = 4,
  parameter logic [1:0] IO_HI   = 2'b11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               rb,

  input  logic               if_ena,
  input  logic [31:0]        if_addr,
  output logic               if_done,
  output logic [31:0]        if_data,

  input  logic               ld_ena,
  input  logic [31:0]        ld_addr,
  input  logic [1:0]         ld_len,
  input  logic [ROB_BIT-1:0] ld_src,
  output logic               ld_done,
  output logic [31:0]        ld_data,
  output logic [ROB_BIT-1:0] ld_tag,

  input  logic               st_ena,
  input  logic [31:0]        st_addr,
  input  logic [1:0]         st_len,
  input  logic [31:0]        st_data,
  output logic               st_done,

  input  logic [7:0]         mem_din,
  output logic [7:0]         mem_dout,
  output logic [31:0]        mem_a,
  output logic               mem_wr,
  input  logic               io_full
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } state_t;

  // Transaction state
  state_t             state_reg;
  logic [2:0]         cnt_reg;     // index of the next byte to present (1..4)
  logic               cool_reg;    // dead cycle after a done or an abort
  logic [31:0]        addr_reg;    // base byte address of the transaction
  logic [1:0]         len_reg;     // bytes-1
  logic [31:0]        wdata_reg;   // store data
  logic [31:0]        rbuf_reg;    // read assembly buffer
  logic [ROB_BIT-1:0] tag_reg;     // load tag captured at accept
  logic               mem_wr_reg;  // write phase active

  // Derived values
  logic [2:0]  byte_idx;
  logic        last_byte;
  logic        io_stall;
  logic [31:0] next_addr;
  logic [31:0] rbuf_next;
  logic [7:0]  wlane [4];

  // cnt_reg runs one ahead of the byte whose address is on mem_a, so the
  // byte being completed at this edge is cnt_reg-1.
  assign byte_idx  = cnt_reg - 3'd1;
  assign last_byte = (byte_idx == {1'b0, len_reg});
  assign next_addr = addr_reg + {29'd0, cnt_reg};

  // The IO stall has to hide the strobe in the same cycle io_full is seen,
  // so the registered write phase is gated combinationally here; the FSM
  // simply holds while the stall lasts and the same byte is retried.
  assign io_stall  = (state_reg == STORE) && io_full && (mem_a[17:16] == IO_HI);
  assign mem_wr    = mem_wr_reg && rdy && !io_stall;

  // Byte lanes: merge the incoming read byte into its lane, and split the
  // store word into lanes for the write mux.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rbuf_next[8*gi +: 8] = (byte_idx[1:0] == 2'(gi)) ? mem_din
                                                               : rbuf_reg[8*gi +: 8];
      assign wlane[gi] = wdata_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 3'd0;
      cool_reg   <= 1'b0;
      addr_reg   <= 32'd0;
      len_reg    <= 2'd0;
      wdata_reg  <= 32'd0;
      rbuf_reg   <= 32'd0;
      tag_reg    <= '0;
      mem_wr_reg <= 1'b0;
      mem_a      <= 32'd0;
      mem_dout   <= 8'd0;
      if_done    <= 1'b0;
      if_data    <= 32'd0;
      ld_done    <= 1'b0;
      ld_data    <= 32'd0;
      ld_tag     <= '0;
      st_done    <= 1'b0;
    end else begin
      // Done outputs are single-cycle pulses.
      if_done <= 1'b0;
      ld_done <= 1'b0;
      st_done <= 1'b0;

      if (rdy) begin
        case (state_reg)
          IDLE: begin
            if (cool_reg) begin
              cool_reg <= 1'b0;
            end else if (st_ena) begin
              // A committed store is accepted even during rollback.
              addr_reg   <= st_addr;
              len_reg    <= st_len;
              wdata_reg  <= st_data;
              mem_a      <= st_addr;
              mem_dout   <= st_data[7:0];
              mem_wr_reg <= 1'b1;
              cnt_reg    <= 3'd1;
              state_reg  <= STORE;
            end else if (!rb && ld_ena) begin
              addr_reg  <= ld_addr;
              len_reg   <= ld_len;
              tag_reg   <= ld_src;
              rbuf_reg  <= 32'd0;
              mem_a     <= ld_addr;
              cnt_reg   <= 3'd1;
              state_reg <= LOAD;
            end else if (!rb && if_ena) begin
              addr_reg  <= if_addr;
              len_reg   <= 2'd3;
              rbuf_reg  <= 32'd0;
              mem_a     <= if_addr;
              cnt_reg   <= 3'd1;
              state_reg <= FETCH;
            end
          end

          FETCH, LOAD: begin
            if (rb) begin
              // Speculative read is squashed without a done pulse.
              state_reg <= IDLE;
              cool_reg  <= 1'b1;
            end else begin
              rbuf_reg <= rbuf_next;
              if (last_byte) begin
                state_reg <= IDLE;
                cool_reg  <= 1'b1;
                if (state_reg == FETCH) begin
                  if_done <= 1'b1;
                  if_data <= rbuf_next;
                end else begin
                  ld_done <= 1'b1;
                  ld_data <= rbuf_next;
                  ld_tag  <= tag_reg;
                end
              end else begin
                mem_a   <= next_addr;
                cnt_reg <= cnt_reg + 3'd1;
              end
            end
          end

          STORE: begin
            if (!io_stall) begin
              if (last_byte) begin
                mem_wr_reg <= 1'b0;
                st_done    <= 1'b1;
                state_reg  <= IDLE;
                cool_reg   <= 1'b1;
              end else begin
                mem_a    <= next_addr;
                mem_dout <= wlane[cnt_reg[1:0]];
                cnt_reg  <= cnt_reg + 3'd1;
              end
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rb;
  logic        if_ena;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ld_ena;
  logic [31:0] ld_addr;
  logic [1:0]  ld_len;
  logic [3:0]  ld_src;
  logic        ld_done;
  logic [31:0] ld_data;
  logic [3:0]  ld_tag;
  logic        st_ena;
  logic [31:0] st_addr;
  logic [1:0]  st_len;
  logic [31:0] st_data;
  logic        st_done;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_full;

  mem_arbiter #(.ROB_BIT(4), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rb(rb),
    .if_ena(if_ena), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_ena(ld_ena), .ld_addr(ld_addr), .ld_len(ld_len), .ld_src(ld_src),
    .ld_done(ld_done), .ld_data(ld_data), .ld_tag(ld_tag),
    .st_ena(st_ena), .st_addr(st_addr), .st_len(st_len), .st_data(st_data),
    .st_done(st_done),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_full(io_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 4 KiB aliased window, read byte for the address on mem_a.
  logic [7:0] ram [0:4095];
  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wlog [$];

  assign mem_din = ram[mem_a[11:0]];

  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_a[11:0]] = mem_dout;
      wlog.push_back('{mem_a, mem_dout});
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // kind: 0 = fetch, 1 = load, 2 = store
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic [3:0]  tag;
    logic        io;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  // Applies one request alone, starting on a negedge with the DUT idle.
  task automatic run_vec(input int idx);
    vec_t v;
    int   n;
    int   rd_wr;
    logic seen;
    logic d;
    v = vecs[idx];
    io_full = v.io;
    wlog.delete();
    case (v.kind)
      0: begin if_addr = v.addr; if_ena = 1'b1; end
      1: begin ld_addr = v.addr; ld_len = v.len; ld_src = v.tag; ld_ena = 1'b1; end
      default: begin st_addr = v.addr; st_len = v.len; st_data = v.data; st_ena = 1'b1; end
    endcase
    n = 0; rd_wr = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (v.kind != 2 && mem_wr) rd_wr++;
      d = (v.kind == 0) ? if_done : (v.kind == 1) ? ld_done : st_done;
      seen = d;
    end
    if_ena = 1'b0; ld_ena = 1'b0; st_ena = 1'b0;
    check($sformatf("v%0d_latency", idx), 32'(n), 32'(v.exp_lat));
    if (v.kind == 0) begin
      check($sformatf("v%0d_if_data", idx), if_data, v.exp_data);
    end else if (v.kind == 1) begin
      check($sformatf("v%0d_ld_data", idx), ld_data, v.exp_data);
      check($sformatf("v%0d_ld_tag", idx), {28'd0, ld_tag}, {28'd0, v.tag});
    end
    if (v.kind != 2) check($sformatf("v%0d_no_write_on_read", idx), 32'(rd_wr), 32'd0);
    @(negedge clk);
    d = (v.kind == 0) ? if_done : (v.kind == 1) ? ld_done : st_done;
    check($sformatf("v%0d_done_one_cycle", idx), {31'd0, d}, 32'd0);
    if (v.kind == 2) begin
      check($sformatf("v%0d_write_count", idx), 32'(wlog.size()), 32'(v.len) + 32'd1);
      for (int k = 0; k < wlog.size() && k <= int'(v.len); k++) begin
        check($sformatf("v%0d_wr%0d_addr", idx, k), wlog[k].a, v.addr + 32'(k));
        check($sformatf("v%0d_wr%0d_byte", idx, k), {24'd0, wlog[k].d}, {24'd0, v.data[8*k +: 8]});
      end
    end
    $display("txn %0d kind=%0d addr=0x%08h len=%0d latency=%0d if_data=0x%08h ld_data=0x%08h ld_tag=%0d",
             idx, v.kind, v.addr, v.len, n, if_data, ld_data, ld_tag);
    io_full = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st_n, ld_n, if_n, wr_cnt;

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22;
    ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ram[12'hFFE] = 8'hA1; ram[12'hFFF] = 8'hB2;
    ram[12'h000] = 8'hC3; ram[12'h001] = 8'hD4;

    //            kind addr           len   data           tag   io    exp_data       lat
    vecs[0]  = '{1, 32'h0000_0100, 2'd3, 32'h0,          4'd5, 1'b0, 32'h4433_2211, 5};
    vecs[1]  = '{1, 32'h0000_0101, 2'd1, 32'h0,          4'd9, 1'b0, 32'h0000_3322, 3};
    vecs[2]  = '{1, 32'h0000_0103, 2'd0, 32'h0,          4'hF, 1'b0, 32'h0000_0044, 2};
    vecs[3]  = '{0, 32'h0000_0100, 2'd3, 32'h0,          4'd0, 1'b0, 32'h4433_2211, 5};
    vecs[4]  = '{2, 32'h0000_0200, 2'd1, 32'h0000_BEEF,  4'd0, 1'b0, 32'h0,         3};
    vecs[5]  = '{2, 32'h0000_0300, 2'd3, 32'hCAFE_F00D,  4'd0, 1'b0, 32'h0,         5};
    vecs[6]  = '{1, 32'h0000_0300, 2'd3, 32'h0,          4'd3, 1'b0, 32'hCAFE_F00D, 5};
    vecs[7]  = '{2, 32'h0000_0302, 2'd0, 32'h1234_5677,  4'd0, 1'b0, 32'h0,         2};
    vecs[8]  = '{1, 32'h0000_0300, 2'd3, 32'h0,          4'd1, 1'b0, 32'hCA77_F00D, 5};
    vecs[9]  = '{1, 32'hFFFF_FFFE, 2'd3, 32'h0,          4'd2, 1'b0, 32'hD4C3_B2A1, 5};
    vecs[10] = '{0, 32'h0000_0201, 2'd3, 32'h0,          4'd0, 1'b0, 32'h0000_00BE, 5};
    vecs[11] = '{2, 32'h0002_0005, 2'd0, 32'h0000_0066,  4'd0, 1'b1, 32'h0,         2};

    rst = 1'b1; rdy = 1'b1; rb = 1'b0; io_full = 1'b0;
    if_ena = 1'b0; if_addr = 32'h0;
    ld_ena = 1'b0; ld_addr = 32'h0; ld_len = 2'd0; ld_src = 4'd0;
    st_ena = 1'b0; st_addr = 32'h0; st_len = 2'd0; st_data = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
    check("rst_dones", {29'd0, if_done, ld_done, st_done}, 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_ld_data", ld_data, 32'h0);
    check("rst_ld_tag", {28'd0, ld_tag}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_mem_a", mem_a, 32'h0);

    // Table-driven single transactions
    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Simultaneous requests: store, then load, then fetch, with a dead cycle
    st_addr = 32'h210; st_len = 2'd0; st_data = 32'h5A;
    ld_addr = 32'h100; ld_len = 2'd1; ld_src = 4'd7;
    if_addr = 32'h100;
    st_ena = 1'b1; ld_ena = 1'b1; if_ena = 1'b1;
    st_n = 0; ld_n = 0; if_n = 0;
    for (int n = 1; n <= 40 && if_n == 0; n++) begin
      @(negedge clk);
      if (st_done && st_n == 0) begin st_n = n; st_ena = 1'b0; end
      if (ld_done && ld_n == 0) begin ld_n = n; ld_ena = 1'b0; end
      if (if_done && if_n == 0) begin if_n = n; if_ena = 1'b0; end
    end
    st_ena = 1'b0; ld_ena = 1'b0; if_ena = 1'b0;
    check("prio_st_done_cycle", 32'(st_n), 32'd2);
    check("prio_ld_done_cycle", 32'(ld_n), 32'd6);
    check("prio_if_done_cycle", 32'(if_n), 32'd12);
    check("prio_ld_data", ld_data, 32'h0000_2211);
    check("prio_if_data", if_data, 32'h4433_2211);
    $display("txn prio st@%0d ld@%0d if@%0d", st_n, ld_n, if_n);
    repeat (3) @(negedge clk);

    // Rollback two cycles into a word load, then a new load is held waiting
    ld_addr = 32'h100; ld_len = 2'd3; ld_src = 4'd5; ld_ena = 1'b1;
    ld_n = 0; wr_cnt = 0;
    for (int n = 1; n <= 30 && ld_n == 0; n++) begin
      @(negedge clk);
      if (mem_wr) wr_cnt++;
      if (ld_done) ld_n = n;
      if (n == 2) rb = 1'b1;
      if (n == 3) begin rb = 1'b0; ld_addr = 32'h103; ld_len = 2'd0; ld_src = 4'd4; end
      if (n == 4) check("rb_mem_a_hold", mem_a, 32'h101);
      if (n == 5) check("rb_reaccept_addr", mem_a, 32'h103);
    end
    ld_ena = 1'b0;
    check("rb_next_done_cycle", 32'(ld_n), 32'd6);
    check("rb_ld_data", ld_data, 32'h44);
    check("rb_ld_tag", {28'd0, ld_tag}, 32'd4);
    check("rb_no_write", 32'(wr_cnt), 32'd0);
    $display("txn rollback: replacement load done@%0d data=0x%08h", ld_n, ld_data);
    repeat (3) @(negedge clk);

    // Byte store into the IO region while io_full is high for 3 cycles
    wlog.delete();
    st_addr = 32'h0003_0000; st_len = 2'd0; st_data = 32'h99; st_ena = 1'b1;
    io_full = 1'b1;
    wr_cnt = 0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (mem_wr) wr_cnt++;
      if (st_done) wr_cnt++;
    end
    check("io_stall_no_write", 32'(wr_cnt), 32'd0);
    @(posedge clk);
    #1 io_full = 1'b0;
    @(negedge clk);
    check("io_write_strobe", {31'd0, mem_wr}, 32'd1);
    check("io_write_addr", mem_a, 32'h0003_0000);
    check("io_write_byte", {24'd0, mem_dout}, 32'h99);
    @(negedge clk);
    check("io_st_done", {31'd0, st_done}, 32'd1);
    check("io_wr_after", {31'd0, mem_wr}, 32'd0);
    st_ena = 1'b0;
    check("io_write_count", 32'(wlog.size()), 32'd1);
    $display("txn io store: writes=%0d", wlog.size());
    repeat (3) @(negedge clk);

    // rdy low for 4 cycles in the middle of a fetch
    if_addr = 32'h100; if_ena = 1'b1; if_n = 0;
    for (int n = 1; n <= 30 && if_n == 0; n++) begin
      @(negedge clk);
      if (if_done) if_n = n;
      if (n == 2) rdy = 1'b0;
      if (n == 5) check("rdy_mem_a_frozen", mem_a, 32'h101);
      if (n == 6) rdy = 1'b1;
    end
    if_ena = 1'b0; rdy = 1'b1;
    check("rdy_if_latency", 32'(if_n), 32'd9);
    check("rdy_if_data", if_data, 32'h4433_2211);
    $display("txn rdy-freeze fetch: done@%0d data=0x%08h", if_n, if_data);
    repeat (3) @(negedge clk);

    // rb in IDLE blocks the load but not the store
    rb = 1'b1;
    ld_addr = 32'h102; ld_len = 2'd0; ld_src = 4'd6; ld_ena = 1'b1;
    st_addr = 32'h220; st_len = 2'd0; st_data = 32'h3C; st_ena = 1'b1;
    st_n = 0; ld_n = 0;
    for (int n = 1; n <= 30 && ld_n == 0; n++) begin
      @(negedge clk);
      if (st_done && st_n == 0) begin st_n = n; st_ena = 1'b0; end
      if (ld_done) ld_n = n;
      if (n == 4) rb = 1'b0;
    end
    ld_ena = 1'b0; st_ena = 1'b0; rb = 1'b0;
    check("rbidle_st_done_cycle", 32'(st_n), 32'd2);
    check("rbidle_ld_done_cycle", 32'(ld_n), 32'd6);
    check("rbidle_ld_data", ld_data, 32'h33);
    check("rbidle_ld_tag", {28'd0, ld_tag}, 32'd6);
    check("rbidle_store_ram", {24'd0, ram[12'h220]}, 32'h3C);
    $display("txn rb-idle: store done@%0d load done@%0d", st_n, ld_n);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
